// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: decoded register usage in, stall/issue out.
// master = decode side driving ID fields, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int LAT_W = 3
);
  logic             ID_Valid;
  logic [4:0]       ID_Reg_Rs;
  logic [4:0]       ID_Reg_Rt;
  logic             ID_Uses_Rs;
  logic             ID_Uses_Rt;
  logic             ID_RegWrite;
  logic [4:0]       ID_Reg_Rd;
  logic [LAT_W-1:0] ID_Latency;
  logic             Flush;
  logic             Stall;
  logic             Issue;

  modport master (
    output ID_Valid, ID_Reg_Rs, ID_Reg_Rt,
    output ID_Uses_Rs, ID_Uses_Rt,
    output ID_RegWrite, ID_Reg_Rd,
    output ID_Latency, Flush,
    input  Stall, Issue
  );

  modport slave (
    input  ID_Valid, ID_Reg_Rs, ID_Reg_Rt,
    input  ID_Uses_Rs, ID_Uses_Rt,
    input  ID_RegWrite, ID_Reg_Rd,
    input  ID_Latency, Flush,
    output Stall, Issue
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Issue-side register scoreboard: per-register result countdowns,
// RAW/WAW stall decision, pending mask and saturating stall counter.
// Ports: clk, reset (sync, active-high), id (slave bundle),
// Pending_Mask (per-register outstanding), Stall_Count.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_scoreboard_if.slave id,
  output logic [NREG-1:0]  Pending_Mask,
  output logic [CNT_W-1:0] Stall_Count
);

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] load_val;
  logic             raw_rs;
  logic             raw_rt;
  logic             waw;

  // latency 0 behaves as a single-cycle ALU result
  assign lat_eff  = (id.ID_Latency == '0) ? LAT_W'(1)
                                          : id.ID_Latency;
  assign load_val = lat_eff - 1'b1;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      Pending_Mask[r] = (cnt[r] != '0);
    end
  end

  assign raw_rs = id.ID_Uses_Rs &&
                  (id.ID_Reg_Rs != 5'd0) &&
                  (cnt[id.ID_Reg_Rs] != '0);
  assign raw_rt = id.ID_Uses_Rt &&
                  (id.ID_Reg_Rt != 5'd0) &&
                  (cnt[id.ID_Reg_Rt] != '0);
  // a younger write must not land before an older one
  assign waw    = id.ID_RegWrite &&
                  (id.ID_Reg_Rd != 5'd0) &&
                  (cnt[id.ID_Reg_Rd] > load_val);

  always_comb begin
    id.Stall = !reset && !id.Flush && id.ID_Valid &&
               (raw_rs || raw_rt || waw);
    id.Issue = !reset && id.ID_Valid && !id.Flush &&
               !id.Stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      Stall_Count <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (id.Issue && id.ID_RegWrite &&
            id.ID_Reg_Rd == 5'(r)) begin
          cnt[r] <= load_val;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      if (id.Stall && Stall_Count != '1) begin
        Stall_Count <= Stall_Count + 1'b1;
      end
    end
  end

endmodule
